imem_arbiter: RTL and testbench

Instruction-memory owner and arbiter for the 8-bit CPU. Holds RAM_SIZE 32-bit program words and shares them between two requesters: the CPU fetch port, which reads, and a host loader port, which reads and writes programs. Exposes the whole memory as a flattened bus that drives the CPU's `ram` input directly. One access per cycle; read data is registered.

---
 rtl/imem_arbiter.sv | 108 ++++++++++
 tb/tb_imem_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// Instruction memory shared by the CPU fetch port and a host loader port.
// Define IMEM_ARB_FAIRNESS_EN for round-robin tie-break; otherwise host wins ties.
module imem_arbiter #(
    parameter int RAM_SIZE = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  f_req,
    input  logic [7:0]            f_addr,
    output logic                  f_gnt,
    output logic [31:0]           f_rdata,
    output logic                  f_rvalid,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [7:0]            h_addr,
    input  logic [31:0]           h_wdata,
    output logic                  h_gnt,
    output logic [31:0]           h_rdata,
    output logic                  h_rvalid,
    output logic                  err,
    output logic [15:0]           accs,
    output logic [RAM_SIZE*32-1:0] ram
);

    localparam int AW = (RAM_SIZE > 1) ? $clog2(RAM_SIZE) : 1;

    logic [31:0]   r_mem [RAM_SIZE];
    logic          r_last_host;
    logic [31:0]   r_f_rdata;
    logic [31:0]   r_h_rdata;
    logic          r_f_rvalid;
    logic          r_h_rvalid;
    logic          r_err;
    logic [15:0]   r_accs;

    logic          w_h_win;
    logic          w_f_gnt;
    logic          w_h_gnt;
    logic          w_f_ok;
    logic          w_h_ok;
    logic [AW-1:0] w_f_idx;
    logic [AW-1:0] w_h_idx;

`ifdef IMEM_ARB_FAIRNESS_EN
    assign w_h_win = h_req && (!f_req || !r_last_host);
`else
    assign w_h_win = h_req;
`endif

    assign w_h_gnt = w_h_win && !reset;
    assign w_f_gnt = f_req && !w_h_win && !reset;

    assign w_f_ok  = {1'b0, f_addr} < 9'(RAM_SIZE);
    assign w_h_ok  = {1'b0, h_addr} < 9'(RAM_SIZE);
    assign w_f_idx = f_addr[AW-1:0];
    assign w_h_idx = h_addr[AW-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < RAM_SIZE; i++) begin
                r_mem[i] <= '0;
            end
            r_last_host <= 1'b0;
            r_f_rdata   <= '0;
            r_h_rdata   <= '0;
            r_f_rvalid  <= 1'b0;
            r_h_rvalid  <= 1'b0;
            r_err       <= 1'b0;
            r_accs      <= '0;
        end else begin
            r_f_rvalid <= 1'b0;
            r_h_rvalid <= 1'b0;
            if (w_f_gnt) begin
                r_last_host <= 1'b0;
                r_accs      <= r_accs + 16'd1;
                r_f_rvalid  <= 1'b1;
                r_f_rdata   <= w_f_ok ? r_mem[w_f_idx] : 32'h0;
                if (!w_f_ok) r_err <= 1'b1;
            end
            if (w_h_gnt) begin
                r_last_host <= 1'b1;
                r_accs      <= r_accs + 16'd1;
                if (!w_h_ok) r_err <= 1'b1;
                // Out-of-range writes are dropped but still count as accesses
                if (h_we) begin
                    if (w_h_ok) r_mem[w_h_idx] <= h_wdata;
                end else begin
                    r_h_rvalid <= 1'b1;
                    r_h_rdata  <= w_h_ok ? r_mem[w_h_idx] : 32'h0;
                end
            end
        end
    end

    for (genvar g = 0; g < RAM_SIZE; g++) begin : g_ram
        assign ram[g*32 +: 32] = r_mem[g];
    end

    assign f_gnt    = w_f_gnt;
    assign h_gnt    = w_h_gnt;
    assign f_rdata  = r_f_rdata;
    assign h_rdata  = r_h_rdata;
    assign f_rvalid = r_f_rvalid;
    assign h_rvalid = r_h_rvalid;
    assign err      = r_err;
    assign accs     = r_accs;

endmodule

// File: tb/tb_imem_arbiter.sv
// Scoreboard bench for imem_arbiter: expected read words are queued at grant
// time and retired by a monitor when rvalid appears.
module tb_imem_arbiter;

    localparam int RS = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic          f_req;
    logic [7:0]    f_addr;
    logic          f_gnt;
    logic [31:0]   f_rdata;
    logic          f_rvalid;
    logic          h_req;
    logic          h_we;
    logic [7:0]    h_addr;
    logic [31:0]   h_wdata;
    logic          h_gnt;
    logic [31:0]   h_rdata;
    logic          h_rvalid;
    logic          err;
    logic [15:0]   accs;
    logic [RS*32-1:0] ram;

    int total = 0;
    int bad   = 0;
    logic [31:0] fq[$];
    logic [31:0] hq[$];
    logic [31:0] exp_f;
    logic [31:0] exp_h;
    logic [RS*32-1:0] snap;
    logic [RS*32-1:0] mask;
    logic [15:0] accs0;

    imem_arbiter #(.RAM_SIZE(RS)) dut (
        .clk(clk), .reset(reset),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt),
        .f_rdata(f_rdata), .f_rvalid(f_rvalid),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rdata(h_rdata), .h_rvalid(h_rvalid),
        .err(err), .accs(accs), .ram(ram)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (f_rvalid === 1'b1) begin
            total++;
            if (fq.size() == 0) begin
                bad++;
                $display("FAIL f_rvalid_spurious got=1 exp=0");
            end else begin
                exp_f = fq.pop_front();
                if (f_rdata !== exp_f) begin
                    bad++;
                    $display("FAIL f_rdata got=%h exp=%h", f_rdata, exp_f);
                end
            end
        end
        if (h_rvalid === 1'b1) begin
            total++;
            if (hq.size() == 0) begin
                bad++;
                $display("FAIL h_rvalid_spurious got=1 exp=0");
            end else begin
                exp_h = hq.pop_front();
                if (h_rdata !== exp_h) begin
                    bad++;
                    $display("FAIL h_rdata got=%h exp=%h", h_rdata, exp_h);
                end
            end
        end
    end

    task automatic do_host(input logic we, input logic [7:0] a,
                           input logic [31:0] d, input logic [31:0] e);
        bit done = 0;
        h_req = 1; h_we = we; h_addr = a; h_wdata = d;
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            if (h_gnt === 1'b1) begin
                done = 1;
                if (!we) hq.push_back(e);
            end
            @(posedge clk); #1;
        end
        h_req = 0; h_we = 0;
        if (!done) begin
            total++; bad++;
            $display("FAIL h_gnt_timeout got=0 exp=1");
        end
    endtask

    task automatic do_fetch(input logic [7:0] a, input logic [31:0] e);
        bit done = 0;
        f_req = 1; f_addr = a;
        for (int i = 0; i < 8 && !done; i++) begin
            #1;
            if (f_gnt === 1'b1) begin
                done = 1;
                fq.push_back(e);
            end
            @(posedge clk); #1;
        end
        f_req = 0;
        if (!done) begin
            total++; bad++;
            $display("FAIL f_gnt_timeout got=0 exp=1");
        end
    endtask

    task automatic pulse_reset();
        reset = 1; #4; reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        reset = 1; f_req = 1; f_addr = 0;
        h_req = 0; h_we = 0; h_addr = 0; h_wdata = 0;
        @(posedge clk); #1;
        total++;
        if (f_gnt !== 1'b0 || h_gnt !== 1'b0) begin
            bad++; $display("FAIL rst_gnt got=%b%b exp=00", f_gnt, h_gnt);
        end
        total++;
        if (accs !== 16'h0 || err !== 1'b0) begin
            bad++; $display("FAIL rst_state accs=%h err=%b exp=0", accs, err);
        end
        total++;
        if (ram !== '0 || f_rvalid !== 0 || h_rvalid !== 0) begin
            bad++; $display("FAIL rst_mem ram=%h exp=0", ram);
        end
        f_req = 0;
        reset = 0;
    endtask

    task automatic test_load();
        do_host(1, 8'd0, 32'h000400AA, 32'h0);
        do_host(1, 8'd6, 32'h00030000, 32'h0);
        total++;
        if (ram[31:0] !== 32'h000400AA || ram[223:192] !== 32'h00030000) begin
            bad++;
            $display("FAIL load_words got=%h,%h exp=000400aa,00030000",
                     ram[31:0], ram[223:192]);
        end
        mask = ram;
        mask[31:0] = '0;
        mask[223:192] = '0;
        total++;
        if (mask !== '0) begin
            bad++; $display("FAIL load_others got=%h exp=0", mask);
        end
        total++;
        if (accs !== 16'd2 || err !== 1'b0) begin
            bad++; $display("FAIL load_accs accs=%0d err=%b exp=2,0", accs, err);
        end
    endtask

    task automatic test_fetch();
        f_req = 1; f_addr = 0;
        #1;
        total++;
        if (f_gnt !== 1'b1 || h_gnt !== 1'b0) begin
            bad++; $display("FAIL fetch_gnt got=%b exp=1", f_gnt);
        end
        fq.push_back(32'h000400AA);
        @(posedge clk); #1;
        f_req = 0;
        total++;
        if (f_rvalid !== 1'b1 || f_rdata !== 32'h000400AA) begin
            bad++;
            $display("FAIL fetch_data got=%b/%h exp=1/000400aa", f_rvalid, f_rdata);
        end
        @(posedge clk); #1;
        total++;
        if (f_rvalid !== 1'b0 || f_rdata !== 32'h000400AA) begin
            bad++; $display("FAIL fetch_pulse got=%b/%h exp=0/hold", f_rvalid, f_rdata);
        end
        do_host(0, 8'd6, 32'h0, 32'h00030000);
    endtask

    task automatic test_back_to_back();
        do_host(1, 8'd3, 32'hDEADBEEF, 32'h0);
        total++;
        if (ram[127:96] !== 32'hDEADBEEF) begin
            bad++; $display("FAIL b2b_ram got=%h exp=deadbeef", ram[127:96]);
        end
        do_fetch(8'd3, 32'hDEADBEEF);
        do_fetch(8'd6, 32'h00030000);
        @(posedge clk); #1;
    endtask

    task automatic test_contention();
        logic exp_host;
        pulse_reset();
        do_host(1, 8'd1, 32'h11112222, 32'h0);
        do_host(1, 8'd2, 32'h33334444, 32'h0);
        do_fetch(8'd1, 32'h11112222);
        f_req = 1; f_addr = 8'd2;
        h_req = 1; h_we = 0; h_addr = 8'd1;
        for (int c = 0; c < 4; c++) begin
            #1;
`ifdef IMEM_ARB_FAIRNESS_EN
            exp_host = (c % 2) == 0;
`else
            exp_host = 1'b1;
`endif
            total++;
            if (h_gnt !== exp_host || f_gnt !== !exp_host) begin
                bad++;
                $display("FAIL cont_gnt cyc=%0d got=h%b/f%b exp=h%b", c, h_gnt, f_gnt, exp_host);
            end
            if (exp_host) hq.push_back(32'h11112222);
            else fq.push_back(32'h33334444);
            @(posedge clk);
            if (c < 3) #1;
        end
        #1;
        f_req = 0; h_req = 0;
        total++;
        if (accs !== 16'd7) begin
            bad++; $display("FAIL cont_accs got=%0d exp=7", accs);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_out_of_range();
        snap = ram;
        accs0 = accs;
        do_host(1, 8'd8, 32'hCAFEF00D, 32'h0);
        total++;
        if (ram !== snap || err !== 1'b1) begin
            bad++; $display("FAIL oor_write err=%b ram_changed=%b exp=1,0", err, ram !== snap);
        end
        do_fetch(8'd200, 32'h0);
        do_host(0, 8'd255, 32'h0, 32'h0);
        @(posedge clk); #1;
        total++;
        if (accs !== accs0 + 16'd3 || err !== 1'b1) begin
            bad++; $display("FAIL oor_accs got=%0d exp=%0d", accs, accs0 + 16'd3);
        end
    endtask

    task automatic test_async_reset();
        do_fetch(8'd1, 32'h11112222);
        @(posedge clk); #1;
        total++;
        if (fq.size() != 0 || hq.size() != 0) begin
            bad++; $display("FAIL queue_drain got=%0d/%0d exp=0/0", fq.size(), hq.size());
        end
        h_req = 1; h_we = 1; h_addr = 8'd5; h_wdata = 32'h55AA55AA;
        #1;
        total++;
        if (h_gnt !== 1'b1) begin
            bad++; $display("FAIL ar_pending got=%b exp=1", h_gnt);
        end
        reset = 1;
        #1;
        total++;
        if (accs !== 16'h0 || err !== 1'b0 || ram !== '0 || h_gnt !== 1'b0) begin
            bad++; $display("FAIL ar_immediate accs=%h err=%b gnt=%b exp=0", accs, err, h_gnt);
        end
        total++;
        if (f_rdata !== 32'h0 || h_rdata !== 32'h0 || f_rvalid !== 0 || h_rvalid !== 0) begin
            bad++; $display("FAIL ar_rdata got=%h/%h exp=0/0", f_rdata, h_rdata);
        end
        @(posedge clk); #1;
        h_req = 0; h_we = 0;
        reset = 0;
        @(posedge clk); #1;
        total++;
        if (ram[191:160] !== 32'h0 || accs !== 16'h0 || h_rvalid !== 1'b0) begin
            bad++; $display("FAIL ar_after w5=%h accs=%0d exp=0,0", ram[191:160], accs);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load();
        test_fetch();
        test_back_to_back();
        test_contention();
        test_out_of_range();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
